// File: rtl/snow64_ext_dat_acc_arbiter.sv
// ---------------------------------------------------------------------------
// snow64_ext_dat_acc_arbiter
//
// Purpose:
//   Round-robin arbiter that multiplexes NUM_CHANNELS internal requesters
//   (instruction fetch, LAR load/store, ...) onto one external data access
//   port (memory or IO) using the req/valid access protocol. Only one
//   transaction is outstanding at a time: IDLE -> BUS -> RESP -> IDLE.
//
// Optional feature:
//   `SNOW64_EXT_DAT_ACC_ARBITER_TIMEOUT_EN` - when defined, a BUS phase that
//   sees no in_bus_valid for TIMEOUT_CYCLES cycles is aborted and reported
//   through out_err. When undefined, BUS waits forever and out_err is 0.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   in_req[N]                per-channel request, held until out_valid
//   in_access_type[N]        per-channel 0 = read, 1 = write
//   in_addr[N*ADDR_WIDTH]    per-channel address, channel i at [i*AW +: AW]
//   in_data[N*DATA_WIDTH]    per-channel write data, packed the same way
//   out_valid[N]             one-cycle completion pulse for granted channel
//   out_err[N]               one-cycle abort pulse, coincident with out_valid
//   out_data[DATA_WIDTH]     read data, meaningful while out_valid is high
//   out_bus_req              external request
//   out_bus_access_type      external access type
//   out_bus_addr             external address
//   out_bus_data             external write data
//   in_bus_valid             external completion
//   in_bus_data              external read data
// ---------------------------------------------------------------------------
module snow64_ext_dat_acc_arbiter #(
  parameter int NUM_CHANNELS   = 4,
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 256,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_CHANNELS-1:0]            in_req,
  input  logic [NUM_CHANNELS-1:0]            in_access_type,
  input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] in_addr,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] in_data,
  output logic [NUM_CHANNELS-1:0]            out_valid,
  output logic [NUM_CHANNELS-1:0]            out_err,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic                               out_bus_req,
  output logic                               out_bus_access_type,
  output logic [ADDR_WIDTH-1:0]              out_bus_addr,
  output logic [DATA_WIDTH-1:0]              out_bus_data,
  input  logic                               in_bus_valid,
  input  logic [DATA_WIDTH-1:0]              in_bus_data
);

  localparam int GW = $clog2(NUM_CHANNELS);

  // Elaboration-time sanity check of the parameter ranges.
  if (NUM_CHANNELS < 2 || NUM_CHANNELS > 16 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("snow64_ext_dat_acc_arbiter: NUM_CHANNELS must be 2..16, TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [GW-1:0]           r_last_grant;
  logic [GW-1:0]           r_grant;
  logic                    r_type;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [DATA_WIDTH-1:0]   r_out_data;
  logic                    w_any;
  logic [GW-1:0]           w_pick;
  logic [GW:0]             w_sum;
  logic                    w_timeout;

  // Unpacked per-channel views of the packed address/data buses.
  logic [ADDR_WIDTH-1:0]   w_ch_addr [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0]   w_ch_data [NUM_CHANNELS];

  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_unpack
    assign w_ch_addr[gi] = in_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_ch_data[gi] = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin pick: search offsets N..1 from last_grant so that the
  // smallest offset with a pending request is assigned last and wins.
  // The one-extra-bit sum covers last_grant + offset without overflow.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_sum  = '0;
    for (int off = NUM_CHANNELS; off >= 1; off--) begin
      w_sum = {1'b0, r_last_grant} + (GW+1)'(off);
      if (w_sum >= (GW+1)'(NUM_CHANNELS)) begin
        w_sum = w_sum - (GW+1)'(NUM_CHANNELS);
      end
      if (in_req[w_sum[GW-1:0]]) begin
        w_any  = 1'b1;
        w_pick = w_sum[GW-1:0];
      end
    end
  end

`ifdef SNOW64_EXT_DAT_ACC_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] r_cnt;
  logic          r_err;

  // Counter is 0 in the first BUS cycle, so hitting TIMEOUT_CYCLES-1
  // means TIMEOUT_CYCLES BUS cycles have elapsed without completion.
  assign w_timeout = (r_state == ST_BUS) && !in_bus_valid &&
                     (r_cnt == CW'(TIMEOUT_CYCLES-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          r_err <= 1'b0;
        end
        ST_BUS: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_timeout) begin
            r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic. in_bus_valid only matters in BUS.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_any) w_state_next = ST_BUS;
      ST_BUS:  if (in_bus_valid || w_timeout) w_state_next = ST_RESP;
      ST_RESP: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Datapath registers: requester fields are sampled only on a grant in
  // IDLE, so anything the requester does while in flight is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= GW'(NUM_CHANNELS-1);
      r_grant      <= '0;
      r_type       <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_out_data   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant      <= w_pick;
            r_last_grant <= w_pick;
            r_type       <= in_access_type[w_pick];
            r_addr       <= w_ch_addr[w_pick];
            r_data       <= w_ch_data[w_pick];
          end
        end
        ST_BUS: begin
          // Completion wins over a coinciding timeout.
          if (in_bus_valid) begin
            r_out_data <= in_bus_data;
          end else if (w_timeout) begin
            r_out_data <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic: everything derives from registers only, so there is no
  // combinational path from in_* to out_bus_*.
  always_comb begin
    out_valid           = '0;
    out_err             = '0;
    out_bus_req         = (r_state == ST_BUS);
    out_bus_access_type = r_type;
    out_bus_addr        = r_addr;
    out_bus_data        = r_data;
    out_data            = r_out_data;
    if (r_state == ST_RESP) begin
      out_valid[r_grant] = 1'b1;
`ifdef SNOW64_EXT_DAT_ACC_ARBITER_TIMEOUT_EN
      out_err[r_grant]   = r_err;
`endif
    end
  end

endmodule
